// File: rtl/ann_operand_sequencer.sv
// Assembles serial words into neuron operands, holds them SETTLE_CYCLES, then captures y_i (last word to res_valid = SETTLE_CYCLES edges).
// in_ready is high only while loading; a held result stalls intake. ANN_KEEP_WEIGHTS_EN enables A/B-only reloads with retained weights.
module ann_operand_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             weight_reload,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] dw1_o,
  output logic [WIDTH-1:0] dw2_o,
  output logic [WIDTH-1:0] dw3_o,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;
  localparam logic [3:0] CNT_LAST  = 4'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] dw1_q, dw1_d, dw2_q, dw2_d, dw3_q, dw3_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_accept;
  logic [2:0]       last_idx;

`ifdef ANN_KEEP_WEIGHTS_EN
  logic wl_q, wl_d, short_q, short_d, short_now;
  // The short/full decision is taken at the index-0 accept and held for the rest of the load.
  assign short_now = (idx_q == 3'd0) ? (wl_q && !weight_reload) : short_q;
  assign last_idx  = short_now ? 3'd1 : 3'd4;
`else
  logic unused_weight_reload;
  assign unused_weight_reload = weight_reload;
  assign last_idx = 3'd4;
`endif

  assign in_accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    dw1_d       = dw1_q;
    dw2_d       = dw2_q;
    dw3_d       = dw3_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
`ifdef ANN_KEEP_WEIGHTS_EN
    wl_d        = wl_q;
    short_d     = short_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (in_accept) begin
          case (idx_q)
            3'd0:    a_d   = in_data;
            3'd1:    b_d   = in_data;
            3'd2:    dw1_d = in_data;
            3'd3:    dw2_d = in_data;
            default: dw3_d = in_data;
          endcase
`ifdef ANN_KEEP_WEIGHTS_EN
          if (idx_q == 3'd0) short_d = short_now;
`endif
          if (idx_q == last_idx) begin
            state_d = ST_SETTLE;
            idx_d   = 3'd0;
            cnt_d   = 4'd0;
`ifdef ANN_KEEP_WEIGHTS_EN
            if (!short_now) wl_d = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          res_data_d  = y_i;
          res_valid_d = 1'b1;
          state_d     = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (res_ready && res_valid_q) begin
          res_valid_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    // Registered so in_ready stays low through reset and has no path from in_valid/res_ready.
    in_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      idx_q       <= 3'd0;
      cnt_q       <= 4'd0;
      a_q         <= '0;
      b_q         <= '0;
      dw1_q       <= '0;
      dw2_q       <= '0;
      dw3_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef ANN_KEEP_WEIGHTS_EN
      wl_q        <= 1'b0;
      short_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dw1_q       <= dw1_d;
      dw2_q       <= dw2_d;
      dw3_q       <= dw3_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef ANN_KEEP_WEIGHTS_EN
      wl_q        <= wl_d;
      short_q     <= short_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign a_o       = a_q;
  assign b_o       = b_q;
  assign dw1_o     = dw1_q;
  assign dw2_o     = dw2_q;
  assign dw3_o     = dw3_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_ann_operand_sequencer.sv
// Scoreboard bench for ann_operand_sequencer: drives serial operand words, models the neuron and expected results.
module tb_ann_operand_sequencer;
  localparam int W      = 32;
  localparam int SETTLE = 2;
`ifdef ANN_KEEP_WEIGHTS_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         weight_reload = 1'b0;
  logic         res_ready = 1'b0;
  logic         in_ready, res_valid;
  logic [W-1:0] a_o, b_o, dw1_o, dw2_o, dw3_o, y_i, res_data;

  ann_operand_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .weight_reload(weight_reload), .a_o(a_o), .b_o(b_o), .dw1_o(dw1_o), .dw2_o(dw2_o),
    .dw3_o(dw3_o), .y_i(y_i), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  // Combinational neuron, wrapping modulo 2^32.
  assign y_i = (a_o * dw1_o + b_o * dw2_o) * dw3_o + a_o * dw1_o + b_o * dw2_o;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] y, a, b, d1, d2, d3;
    int           rise;
  } exp_t;
  exp_t exp_q[$];

  logic [W-1:0] m_ops[5];
  int           m_idx    = 0;
  bit           m_loaded = 1'b0;
  bit           m_short  = 1'b0;
  int           rr_mode  = 0;   // 0: ready high, 1: ready low, 2: random

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // s = A*dw1 + B*dw2, y = s*dw3 + s = s*(dw3+1), all modulo 2^32.
  function automatic logic [W-1:0] neuron(input logic [W-1:0] a, b, d1, d2, d3);
    bit [63:0] s;
    s = {32'b0, a} * {32'b0, d1} + {32'b0, b} * {32'b0, d2};
    s = {32'b0, s[31:0]} * ({32'b0, d3} + 64'd1);
    return s[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_ops[i] = '0;
    m_idx = 0; m_loaded = 1'b0; m_short = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [W-1:0] w, input bit rl);
    exp_t e;
    if (m_idx == 0) m_short = KEEP && m_loaded && !rl;
    m_ops[m_idx] = w;
    m_idx++;
    if (m_idx == (m_short ? 2 : 5)) begin
      e.a = m_ops[0]; e.b = m_ops[1]; e.d1 = m_ops[2]; e.d2 = m_ops[3]; e.d3 = m_ops[4];
      e.y = neuron(e.a, e.b, e.d1, e.d2, e.d3);
      e.rise = cyc + SETTLE;
      exp_q.push_back(e);
      if (!m_short) m_loaded = 1'b1;
      m_idx = 0;
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send_word(input logic [W-1:0] w, input bit rl);
    int  n = 0;
    bit  done = 1'b0;
    in_data = w; in_valid = 1'b1; weight_reload = rl;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      if (done) model_accept(w, rl);
      else if (++n > 1000) begin
        total++; bad++;
        $display("FAIL send_timeout: in_ready stuck 0, got 0 expected 1 (word %0h)", w);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending results got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'b0;
      default: res_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compares every presented result against the scoreboard head.
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin prev = 1'b0; continue; end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {31'b0, res_valid}, '0);
        end else begin
          if (!prev) begin
            check("rise_cycle", 32'(cyc), 32'(exp_q[0].rise));
            check("a_o", a_o, exp_q[0].a);
            check("b_o", b_o, exp_q[0].b);
            check("dw1_o", dw1_o, exp_q[0].d1);
            check("dw2_o", dw2_o, exp_q[0].d2);
            check("dw3_o", dw3_o, exp_q[0].d3);
          end
          check("res_data", res_data, exp_q[0].y);
          check("in_ready_busy", {31'b0, in_ready}, '0);
          if (res_ready) begin
            void'(exp_q.pop_front());
            @(negedge clk);
            check("in_ready_after_accept", {31'b0, in_ready}, 32'd1);
            check("res_valid_cleared", {31'b0, res_valid}, '0);
            prev = 1'b0;
            continue;
          end
        end
      end
      prev = res_valid;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, a_o, '0);
    check({tag, "_b"}, b_o, '0);
    check({tag, "_dw1"}, dw1_o, '0);
    check({tag, "_dw2"}, dw2_o, '0);
    check({tag, "_dw3"}, dw3_o, '0);
    check({tag, "_res_data"}, res_data, '0);
    check({tag, "_res_valid"}, {31'b0, res_valid}, '0);
    check({tag, "_in_ready"}, {31'b0, in_ready}, '0);
  endtask

  initial begin
    bit           rl;
    int           nw;
    logic [W-1:0] w;
    model_reset();
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back load, in_valid held high.
    for (int i = 2; i <= 6; i++) send_word(32'(i), 1'b0);
    @(negedge clk);
    check("in_ready_drop", {31'b0, in_ready}, '0);
    wait_idle();

    // in_valid toggling between words.
    foreach (m_ops[i]) begin
      w = (i == 4) ? 32'd0 : 32'd1;
      send_word(w, 1'b0);
      idle(1);
    end
    wait_idle();

    // Downstream stall while a word is offered.
    rr_mode = 1;
    for (int i = 0; i < 5; i++) send_word(32'(i + 3), 1'b0);
    nw = 0;
    while (!res_valid && nw < 50) begin idle(1); nw++; end
    check("stall_res_valid", {31'b0, res_valid}, 32'd1);
    in_data = 32'hDEAD_BEEF; in_valid = 1'b1;
    idle(10);
    in_valid = 1'b0;
    rr_mode = 0;
    wait_idle();

    // Reset in the middle of a load.
    for (int i = 0; i < 3; i++) send_word(32'(i + 7), 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 2; i <= 6; i++) send_word(32'(i), 1'b0);
    wait_idle();

    // Products wrap inside the neuron.
    send_word(32'h0001_0000, 1'b0);
    send_word(32'h0, 1'b0);
    send_word(32'h0001_0000, 1'b0);
    send_word(32'h0, 1'b0);
    send_word(32'd7, 1'b0);
    wait_idle();

`ifdef ANN_KEEP_WEIGHTS_EN
    // Full load, short A/B load with kept weights, then forced full reload.
    for (int i = 2; i <= 6; i++) send_word(32'(i), 1'b0);
    wait_idle();
    send_word(32'd1, 1'b0);
    send_word(32'd1, 1'b0);
    wait_idle();
    for (int i = 0; i < 5; i++) send_word((i == 4) ? 32'd0 : 32'd1, 1'b1);
    wait_idle();
`endif

    // Randomized traffic with gaps and random downstream backpressure.
    rr_mode = 2;
    repeat (25) begin
      rl = 1'($urandom_range(0, 1));
      nw = (KEEP && m_loaded && !rl) ? 2 : 5;
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        w = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 20));
        send_word(w, rl);
      end
    end
    wait_idle();
    rr_mode = 0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ann_operand_sequencer.md
Name: ann_operand_sequencer

Overview:
- Upstream feeder and result-capture stage for the combinational ANN neuron datapath.
- The datapath computes y = (A*dw1 + B*dw2)*dw3 + A*dw1 + B*dw2.
- This block accepts a serial stream of 32-bit words over a valid/ready handshake and assembles them into registered operands A, B, dw1, dw2, dw3.
- It holds the operands stable while the multiplier chain settles, then registers the neuron output y and presents it downstream over a second valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result word width (datapath is 32-bit; other values unsupported).
- SETTLE_CYCLES, 2, cycles operands are held before y is sampled; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  WIDTH  serial operand word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word.
- weight_reload  input  1  force a full 5-word load; used only with ANN_KEEP_WEIGHTS_EN, ignored otherwise.
- a_o, b_o  output  WIDTH  registered A, B to the neuron.
- dw1_o, dw2_o, dw3_o  output  WIDTH  registered weights to the neuron.
- y_i  input  WIDTH  neuron output (combinational from the *_o ports).
- res_data  output  WIDTH  captured result.
- res_valid  output  1  res_data valid.
- res_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to LOAD.
  - Word index goes to 0; settle counter goes to 0.
  - a_o, b_o, dw1_o, dw2_o, dw3_o and res_data go to 0.
  - res_valid goes to 0; in_ready goes to 0 while rst_n is low.
  - Reset asserted mid-transaction discards partial operands and any pending result.
- Handshakes:
  - A transfer occurs on a rising edge with valid && ready.
  - in_ready and res_valid are registered or pure state decodes, with no combinational path from in_valid or res_ready.
  - in_ready is 1 only in LOAD.
- FSM states: LOAD, SETTLE, OUTPUT.
- LOAD:
  - Accepted words are stored by index: 0->a_o, 1->b_o, 2->dw1_o, 3->dw2_o, 4->dw3_o.
  - Each unaccepted cycle leaves all registers unchanged; gaps in in_valid are legal.
  - The edge accepting index 4 moves to SETTLE, resets the index to 0, and clears the counter.
- SETTLE:
  - Operands are frozen.
  - The counter increments each edge.
  - On the edge where counter == SETTLE_CYCLES-1: res_data <= y_i, res_valid <= 1, state goes to OUTPUT.
  - res_valid therefore rises exactly SETTLE_CYCLES edges after the last input word is accepted.
- OUTPUT:
  - res_data and res_valid hold until res_ready && res_valid.
  - That edge clears res_valid and returns to LOAD; in_ready is 1 the following cycle.
  - Operands keep their last values; nothing is cleared except res_valid.
- Arithmetic: no computation in this block; y wraps modulo 2^WIDTH inside the neuron and is captured as-is.
- Back-to-back throughput: 5 + SETTLE_CYCLES + 1 cycles minimum per result (res_ready tied high).
- in_valid asserted outside LOAD is ignored; the word is not consumed.

Optional Feature:
- Macro: ANN_KEEP_WEIGHTS_EN.
- Defined:
  - A weights_loaded flag is set after the first complete 5-word load and cleared by reset.
  - When the flag is set and weight_reload is 0 at the cycle the index-0 word is accepted, the transaction is short: only A and B are loaded.
  - In a short transaction, the edge accepting index 1 moves to SETTLE and dw1_o..dw3_o are retained.
  - weight_reload=1 at the index-0 accept forces a full 5-word load.
- Not defined: every transaction is 5 words; weight_reload is unused.

Test Plan:
1. Reset, then stream 2,3,4,5,6 with in_valid held high and res_ready=1.
   - Required: in_ready drops after the 5th word.
   - Required: res_valid rises 2 edges later with res_data=161; in_ready returns 1 cycle after the result is accepted.
2. Stream 1,1,1,1,0 with in_valid toggling 1/0 each cycle.
   - Required: operands are loaded in order despite the gaps; res_data=2.
3. Hold res_ready=0 for 10 cycles after res_valid.
   - Required: res_data is stable and in_ready stays 0; words offered meanwhile are not consumed; the result is released when res_ready=1.
4. Pulse rst_n low after 3 words have been accepted.
   - Required: all outputs are 0 immediately with no clock needed.
   - Required: the next 5 words (2,3,4,5,6) produce 161.
5. Stream A=0x00010000, B=0, dw1=0x00010000, dw2=0, dw3=7.
   - Required: res_data=0 (wrap in the neuron).
   - Repeat with SETTLE_CYCLES=1: res_valid rises 1 edge after the last word.
6. With ANN_KEEP_WEIGHTS_EN: full load 2,3,4,5,6 (161), then a short load 1,1 with weight_reload=0.
   - Required: res_data = (4+5)*6 + 9 = 63.
   - Then weight_reload=1 with 1,1,1,1,0: a full load, res_data=2.
